// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between data_path_TOP and a variable-latency
// instruction memory; req/ack handshake, one-deep decode-stall buffer, flush squash.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instr_d,
  output logic             stall_f,
  output logic [CNT_W-1:0] wait_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, deliver;
  logic [31:0] addr_q, addr_d, ir_q, ir_d, hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    deliver = ((state_q == WAIT && imem_ack) || state_q == HOLD) && !stall_d && !flush_d;
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    ir_d    = flush_d ? NOP_INSTR : stall_d ? ir_q :
              deliver ? (state_q == HOLD ? hold_q : imem_rdata) : NOP_INSTR;
    cnt_d   = (req_q && !imem_ack && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    // req/addr are only released on ack so an outstanding request is never altered
    case (state_q)
      IDLE: begin
        addr_d  = pc;
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT:
        if (imem_ack) begin
          if (flush_d) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else if (stall_d) begin
            hold_d  = imem_rdata;
            req_d   = 1'b0;
            state_d = HOLD;
          end else addr_d = addr_q + 32'd4;
        end else if (flush_d) state_d = DISCARD;
      HOLD:
        if (deliver) begin
          addr_d  = addr_q + 32'd4;
          req_d   = 1'b1;
          state_d = WAIT;
        end else if (flush_d) state_d = IDLE;
      DISCARD:
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= NOP_INSTR;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr_d   = ir_q;
  assign wait_cnt  = cnt_q;
  assign stall_f   = !deliver && !flush_d;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of data_path_TOP.
- Takes the fetch address `pc` from the data path, runs a req/ack handshake to a variable-latency instruction memory, and drives the decode-stage instruction `instr_d`.
- Holds the data path's PC via `stall_f` until an instruction is accepted, buffers one instruction while decode is stalled, and squashes in-flight fetches on branch/jump flush.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word driven on `instr_d` for bubbles and flushes
- CNT_W, 16, width of the saturating memory-wait cycle counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- pc  input  32  next fetch address from data_path_TOP; advances only when `stall_f`=0
- stall_d  input  1  decode stall from hazard logic: hold `instr_d`
- flush_d  input  1  redirect (`pcsrc`≠0): squash decode and any in-flight fetch
- imem_ack  input  1  memory returns `imem_rdata` this cycle
- imem_rdata  input  32  instruction word, valid when `imem_ack`=1
- imem_req  output  1  request outstanding (registered)
- imem_addr  output  32  request address (registered), stable while `imem_req`=1
- instr_d  output  32  decode-stage instruction register
- stall_f  output  1  1 = data path must hold `pc`
- wait_cnt  output  CNT_W  saturating count of cycles with `imem_req`=1 and `imem_ack`=0

Behaviour:
- Reset (`reset`=0, immediate):
  - state=IDLE, `imem_req`=0, `imem_addr`=0
  - `instr_d`=NOP_INSTR, hold_q=0, `wait_cnt`=0
  - `stall_f`=1 combinationally while state≠deliver
- Memory protocol:
  - Once `imem_req` rises, it stays 1 with `imem_addr` unchanged until the cycle `imem_ack`=1.
  - Ack in a cycle with `imem_req`=0 is ignored.
- Definition: deliver = ((WAIT & `imem_ack`) | HOLD) & ~`stall_d` & ~`flush_d`
- `stall_f` = ~deliver & ~`flush_d`. Flush releases the PC so the branch target loads.
- `instr_d` update, in priority order:
  - `flush_d` → NOP_INSTR
  - `stall_d` → hold
  - deliver → fetched word (`imem_rdata` in WAIT, hold_q in HOLD)
  - otherwise → NOP_INSTR (bubble)
- State transitions:
  - IDLE: next edge `imem_addr`←`pc`, `imem_req`←1, →WAIT. This is one idle cycle after reset, flush, or discard.
  - WAIT, ack & deliver: `imem_addr`←`imem_addr`+4, `imem_req` stays 1, stay WAIT. Back-to-back throughput is 1 instr/cycle on zero-wait memory; the +4 matches the data path's pc increment.
  - WAIT, ack & `stall_d` & ~`flush_d`: hold_q←`imem_rdata`, `imem_req`←0, →HOLD.
  - WAIT, ack & `flush_d`: drop data, `imem_req`←0, →IDLE.
  - WAIT, ~ack & `flush_d`: →DISCARD, `imem_req` stays 1 (protocol).
  - WAIT, ~ack, no flush: stay.
  - HOLD: `imem_req`=0.
    - deliver → `imem_addr`←`imem_addr`+4, `imem_req`←1, →WAIT.
    - `flush_d` → →IDLE, hold_q dropped.
    - else stay.
  - DISCARD: `imem_req`=1.
    - Ack → data dropped, `imem_req`←0, →IDLE.
    - Further `flush_d` is ignored; the new pc is sampled in IDLE.
- Simultaneous events:
  - `flush_d` wins over `stall_d` and ack.
  - Reset mid-request drops `imem_req` immediately. The memory must tolerate abandoned requests.
- Addresses: `imem_addr`+4 wraps modulo 2^32 (FFFF_FFFC→0000_0000). Bits [1:0] are passed through unchecked.
- `wait_cnt` increments each cycle with `imem_req`=1 & `imem_ack`=0 (including DISCARD) and saturates at all-ones.

Test Plan:
- Zero-wait sequential: `pc`=0x0, ack tied 1, rdata=addr+0x100 → `imem_addr` 0,4,8,…; `instr_d` 0x100,0x104,0x108 on consecutive cycles; `stall_f`=0 each delivery; `wait_cnt`=0.
- 3-cycle latency: ack after 3 wait cycles, rdata=0x2010_0005 → `stall_f`=1 for 3 cycles, `instr_d`=NOP then 0x2010_0005; `wait_cnt`=3.
- Decode stall: `stall_d`=1 when ack with 0xAABB_CCDD arrives → state HOLD, `imem_req`=0, `instr_d` unchanged; release after 2 cycles → `instr_d`=0xAABB_CCDD, next `imem_addr`=old+4.
- Flush in flight: req at 0x40 pending, `flush_d`=1, `pc`→0x80 → `imem_req` held until ack, returned word dropped, `instr_d`=NOP, next request at 0x80.
- Flush + stall + ack same cycle → `instr_d`=NOP, state IDLE, `stall_f`=0.
- Edge cases: async reset asserted mid-WAIT clears `imem_req` and `instr_d`=NOP without a clock edge; `imem_addr`=0xFFFF_FFFC delivered → next `imem_addr`=0x0000_0000; `wait_cnt` with CNT_W=4 held 20 cycles → 4'hF.
